// File: rtl/sym_vn_lut_loader.sv
// Streams up to 32 LUT pages into two replicated write ports with a one-cycle write pipeline.
// Optional checksum output enabled by defining SYM_VN_LOADER_CHKSUM_EN.
module sym_vn_lut_loader (
    input  logic       write_clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [5:0] num_pages,
    input  logic       abort,
    input  logic [2:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] lut_in_bank0_replicate_0,
    output logic [4:0] page_write_addr_replicate_0,
    output logic [2:0] lut_in_bank0_replicate_1,
    output logic [4:0] page_write_addr_replicate_1,
    output logic       we,
    output logic       busy,
    output logic       done
`ifdef SYM_VN_LOADER_CHKSUM_EN
    ,
    output logic [7:0] chksum
`endif
);

    // Handshake: a beat transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready never depends on in_valid, and abort drops in_ready in the same cycle.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] page_cnt;
    logic [4:0] last_page;
    logic [4:0] start_last;
    logic       accept;
    logic       last_beat;
    logic       start_ok;

    // 0 wraps to 31 through the 5-bit subtraction, so only counts above 32 need clamping.
    assign start_last = (num_pages > 6'd32) ? 5'd31 : (num_pages[4:0] - 5'd1);
    assign start_ok   = (state == IDLE) && start;
    assign accept     = in_valid && in_ready;
    assign last_beat  = accept && (page_cnt == last_page);

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD: begin
                if (abort)          state_next = IDLE;
                else if (last_beat) state_next = FLUSH;
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LOAD: begin
                in_ready = !abort;
                busy     = 1'b1;
            end
            FLUSH: begin
                busy = 1'b1;
                done = !abort;
            end
            default: ;
        endcase
    end

    // Replicas are kept as separate registers so each bank gets its own driver.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            page_cnt                    <= 5'd0;
            last_page                   <= 5'd0;
            we                          <= 1'b0;
            lut_in_bank0_replicate_0    <= 3'd0;
            lut_in_bank0_replicate_1    <= 3'd0;
            page_write_addr_replicate_0 <= 5'd0;
            page_write_addr_replicate_1 <= 5'd0;
        end else begin
            we <= accept;
            if (start_ok) begin
                page_cnt  <= 5'd0;
                last_page <= start_last;
            end else if (accept) begin
                page_cnt <= page_cnt + 5'd1;
            end
            if (accept) begin
                lut_in_bank0_replicate_0    <= in_data;
                lut_in_bank0_replicate_1    <= in_data;
                page_write_addr_replicate_0 <= page_cnt;
                page_write_addr_replicate_1 <= page_cnt;
            end
        end
    end

`ifdef SYM_VN_LOADER_CHKSUM_EN
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            chksum <= 8'd0;
        end else if (start_ok) begin
            chksum <= 8'd0;
        end else if (accept) begin
            chksum <= chksum + {5'b0, in_data};
        end
    end
`endif

endmodule
